fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side consumer for the project's FIFOs. It runs in the FIFO read-clock domain, pops words through the FIFO's `empty`/`rd_en`/`data_out` port and presents them on a valid/ready stream with packet framing (`out_last` every `PKT_LEN` words). A 2-entry output buffer absorbs the FIFO's one-cycle read latency and sustains one word per cycle under continuous `out_ready`.

## Interface
- `WIDTH`, 32: data width; matches the FIFO `WIDTH`.
- `PKT_LEN`, 8: words per packet; legal range 1..2^16.
- `CNT_WIDTH`, 16: width of the `word_count` status counter.

- `rd_clk`  in  1  sole clock, rising edge.
- `rd_reset`  in  1  reset; asynchronous assert, active-high.
- `enable`  in  1  permits new FIFO pops.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd_en`  out  1  pop request to the FIFO `rd_en`.
- `fifo_data`  in  WIDTH  FIFO `data_out`, valid in the cycle after an accepted pop.
- `out_valid`  out  1  head word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  WIDTH  head word.
- `out_last`  out  1  head word is the final word of a packet.
- `word_count`  out  CNT_WIDTH  total words transferred on the output.

## Operation
- State:
  - `count`: buffer occupancy, 0..2.
  - `inflight`: a pop was issued last cycle.
  - `pos`: packet position, 0..PKT_LEN-1.
  - `word_count`.
  - Two WIDTH-bit buffer entries with head/tail pointers.
- Output transfer (`xfer`) = `out_valid & out_ready`.
- Pop request (combinational):
  - `fifo_rd_en = enable & ~fifo_empty & (count + inflight - xfer < 2)`.
  - The same-cycle output transfer counts as credit. No other path asserts `fifo_rd_en`.
- Capture:
  - When `inflight` = 1, `fifo_data` is written to the tail entry at the cycle's clock edge.
  - `inflight` then takes the current value of `fifo_rd_en`.
- Occupancy updates:
  - Capture and `xfer` in the same cycle: `count` is unchanged, head advances, tail advances.
  - Order is strictly FIFO.
  - Capture into a full buffer cannot occur, because the credit rule prevents it.
- Output signals:
  - `out_valid = (count != 0)`.
  - `out_data` = head entry.
  - `out_last = out_valid & (pos == PKT_LEN-1)`.
- Packet position: on `xfer`, `pos` increments; it wraps to 0 after PKT_LEN-1. For PKT_LEN = 1, `out_last` is high on every valid word.
- Word counter: on `xfer`, `word_count` increments modulo 2^CNT_WIDTH, with silent wrap.
- Stall: while `out_valid & ~out_ready`, `out_data` and `out_last` are held stable.
- Disable: when `enable` drops, no new pops are issued. An in-flight word is still captured and the buffered words still drain. `enable` does not affect `pos` or `word_count`.
- Reset:
  - `rd_reset` clears `count`, `inflight`, `pos`, `word_count` and the buffer entries to 0.
  - A word popped in the cycle before reset is discarded. Resetting the FIFO alongside this block is the integrator's responsibility.
- Reset values of outputs: `fifo_rd_en` = 0 (forced while `rd_reset` is high), `out_valid` = 0, `out_data` = 0, `out_last` = 0, `word_count` = 0.

## Timing
- Pop latency: `fifo_rd_en` high in cycle N → `fifo_data` captured at the end of N+1 → `out_valid` high in N+2.
- Minimum latency from `fifo_empty` falling to the first `out_valid` is 2 cycles.
- Throughput: with `out_ready` held high and the FIFO non-empty, one word per cycle after the 2-cycle fill. `fifo_rd_en` stays high every cycle.
- With `out_ready` held low, at most 2 pops are issued; then `fifo_rd_en` stays low until an `xfer` occurs.
- `fifo_empty` rising in the cycle of a pop: that pop is not issued, since the expression includes `~fifo_empty`.
- Combinational paths are `out_ready` → `fifo_rd_en` and `fifo_empty` → `fifo_rd_en`. All other outputs are registered or decoded from registers.

## Test plan
- Reset and idle: assert `rd_reset` mid-stream with 2 words buffered. All outputs are 0 in the same cycle. After release with the FIFO empty, `fifo_rd_en` stays 0 and `out_valid` stays 0.
- Streaming: FIFO preloaded with 1..16, `out_ready` = 1, `PKT_LEN` = 8.
  - `out_data` = 1..16 on consecutive cycles, with the first word 2 cycles after the first pop.
  - `out_last` is high on words 8 and 16.
  - `word_count` ends at 16.
- Backpressure: FIFO holds 1..8, `out_ready` = 0 for 10 cycles.
  - Exactly 2 pops occur and `out_data` holds at 1.
  - Then `out_ready` toggles 1/0. Output sequence 1..8 has no loss and no duplicates.
  - FIFO occupancy drops by exactly one per `xfer`.
- Enable drop: `enable` deasserted the cycle after a pop while streaming. The in-flight word is still delivered, no further `fifo_rd_en` occurs, and the buffered words drain. Re-enabling resumes with the next FIFO word.
- Wrap: `PKT_LEN` = 1, `CNT_WIDTH` = 4, 20 words. `out_last` is high on all 20 words, and `word_count` reads 4 at the end (20 mod 16).

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pops a FIFO read port into a 2-entry buffer and emits a valid/ready stream framed by out_last every PKT_LEN words.
// Pop to out_valid takes 2 cycles; a stalled output holds its word and at most 2 pops are outstanding.
module fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int PKT_LEN   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam int POS_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PKT_LEN - 1);

  logic [1:0]           count_q, count_d;
  logic                 inflight_q;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [WIDTH-1:0]     buf_q [2];
  logic [WIDTH-1:0]     buf_d [2];
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [CNT_WIDTH-1:0] wc_q, wc_d;
  logic                 xfer;
  logic [2:0]           occ;

  assign out_valid  = (count_q != 2'd0);
  assign xfer       = out_valid & out_ready;
  // Occupancy after this cycle: buffered + in flight, less the word leaving now.
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, xfer};
  assign fifo_rd_en = ~rd_reset & enable & ~fifo_empty & (occ < 3'd2);
  assign out_data   = buf_q[head_q];
  assign out_last   = out_valid & (pos_q == POS_LAST);
  assign word_count = wc_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    wc_d    = wc_q;
    count_d = occ[1:0];
    if (inflight_q) begin
      buf_d[tail_q] = fifo_data;
      tail_d        = ~tail_q;
    end
    if (xfer) begin
      head_d = ~head_q;
      wc_d   = wc_q + CNT_WIDTH'(1);
      pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      pos_q      <= '0;
      wc_q       <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      pos_q      <= pos_d;
      wc_q       <= wc_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural FIFOs feed two reader instances (PKT_LEN 8 and PKT_LEN 1 / 4-bit counter).
module tb_fifo_stream_reader;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        rd_clk = 1'b0;
  logic        rd_reset;
  logic        a_en, a_empty, a_rd_en, a_valid, a_ready, a_last;
  logic [31:0] a_fdata, a_data;
  logic [15:0] a_wc;
  logic        b_en, b_empty, b_rd_en, b_valid, b_ready, b_last;
  logic [31:0] b_fdata, b_data;
  logic [3:0]  b_wc;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  int ra = 0, wa = 0, rb = 0, wb = 0;

  exp_t exp_q[$];
  int   a_idx = 0, a_xfers = 0, b_xfers = 0, b_exp = 1;
  int   tests = 0, fails = 0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 rd_clk = ~rd_clk;

  fifo_stream_reader #(.WIDTH(32), .PKT_LEN(8), .CNT_WIDTH(16)) dut_a (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .enable(a_en), .fifo_empty(a_empty),
    .fifo_rd_en(a_rd_en), .fifo_data(a_fdata), .out_valid(a_valid), .out_ready(a_ready),
    .out_data(a_data), .out_last(a_last), .word_count(a_wc));

  fifo_stream_reader #(.WIDTH(32), .PKT_LEN(1), .CNT_WIDTH(4)) dut_b (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .enable(b_en), .fifo_empty(b_empty),
    .fifo_rd_en(b_rd_en), .fifo_data(b_fdata), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .out_last(b_last), .word_count(b_wc));

  // FIFO models: registered read data, flushed together with the reader.
  assign a_empty = (ra == wa);
  assign b_empty = (rb == wb);

  always @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      ra <= wa;
      rb <= wb;
      a_fdata <= '0;
      b_fdata <= '0;
    end else begin
      if (a_rd_en) begin
        a_fdata <= mem_a[ra[5:0]];
        ra <= ra + 1;
      end
      if (b_rd_en) begin
        b_fdata <= mem_b[rb[5:0]];
        rb <= rb + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int v);
    mem_a[wa[5:0]] = 32'(v);
    wa++;
    exp_q.push_back({32'(v), (a_idx % 8) == 7});
    a_idx++;
  endtask

  task automatic push_b(input int v);
    mem_b[wb[5:0]] = 32'(v);
    wb++;
  endtask

  // Monitor at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge rd_clk);
    if (a_valid && prev_stall) begin
      chk("stall_data", {32'd0, a_data}, {32'd0, prev_data});
      chk("stall_last", {63'd0, a_last}, {63'd0, prev_last});
    end
    prev_stall = a_valid && !a_ready;
    prev_data  = a_data;
    prev_last  = a_last;
    if (a_valid && a_ready) begin
      chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("a_data", {32'd0, a_data}, {32'd0, e.d});
        chk("a_last", {63'd0, a_last}, {63'd0, e.l});
      end
      a_xfers++;
    end
    if (b_valid && b_ready) begin
      chk("b_data", {32'd0, b_data}, 64'(b_exp));
      chk("b_last", {63'd0, b_last}, 64'd1);
      b_exp++;
      b_xfers++;
    end
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    int x0, r0, cyc;
    logic rd_seen;
    rd_reset = 1'b1;
    a_en = 1'b0; a_ready = 1'b0;
    b_en = 1'b0; b_ready = 1'b0;
    tick(); tick();
    chk("rst_rd_en", {63'd0, a_rd_en}, 64'd0);
    chk("rst_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_data", {32'd0, a_data}, 64'd0);
    chk("rst_last", {63'd0, a_last}, 64'd0);
    chk("rst_wc", {48'd0, a_wc}, 64'd0);
    rd_reset = 1'b0;
    tick();

    // Streaming 1..16 with out_ready high
    for (int i = 1; i <= 16; i++) push_a(i);
    a_en = 1'b1; a_ready = 1'b1;
    #1;
    chk("first_pop", {63'd0, a_rd_en}, 64'd1);
    tick();
    chk("lat_n1_valid", {63'd0, a_valid}, 64'd0);
    tick();
    chk("lat_n2_valid", {63'd0, a_valid}, 64'd1);
    chk("lat_n2_data", {32'd0, a_data}, 64'd1);
    cyc = 0;
    while (a_xfers < 16 && cyc < 40) begin tick(); cyc++; end
    chk("stream_cycles", 64'(cyc), 64'd16);
    chk("stream_wc", {48'd0, a_wc}, 64'd16);
    chk("stream_idle", {63'd0, a_valid}, 64'd0);

    // Backpressure: out_ready low for 10 cycles, then toggling
    a_ready = 1'b0;
    x0 = a_xfers; r0 = ra;
    for (int i = 1; i <= 8; i++) push_a(i);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_pops", 64'(ra - r0), 64'd2);
    chk("bp_hold_data", {32'd0, a_data}, 64'd1);
    chk("bp_rd_en", {63'd0, a_rd_en}, 64'd0);
    cyc = 0;
    while (a_xfers < x0 + 8 && cyc < 40) begin
      a_ready = (cyc % 2 == 0);
      tick();
      chk("bp_credit", {63'd0, ((ra - r0) - (a_xfers - x0)) <= 2}, 64'd1);
      cyc++;
    end
    chk("bp_xfers", 64'(a_xfers - x0), 64'd8);
    chk("bp_pops_total", 64'(ra - r0), 64'd8);

    // Enable drop one cycle after a pop
    a_ready = 1'b1;
    x0 = a_xfers; r0 = ra;
    for (int i = 101; i <= 110; i++) push_a(i);
    tick(); tick(); tick();
    a_en = 1'b0;
    #1;
    chk("dis_rd_en", {63'd0, a_rd_en}, 64'd0);
    rd_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_seen = rd_seen | a_rd_en;
      tick();
    end
    chk("dis_no_pop", {63'd0, rd_seen}, 64'd0);
    chk("dis_pops", 64'(ra - r0), 64'd3);
    chk("dis_drained", 64'(a_xfers - x0), 64'd3);
    chk("dis_idle", {63'd0, a_valid}, 64'd0);
    a_en = 1'b1;
    cyc = 0;
    while (a_xfers < x0 + 10 && cyc < 40) begin tick(); cyc++; end
    chk("reen_pops", 64'(ra - r0), 64'd10);
    chk("reen_wc", {48'd0, a_wc}, 64'd34);

    // Reset mid-stream with 2 words buffered
    a_ready = 1'b0;
    for (int i = 201; i <= 204; i++) push_a(i);
    tick(); tick(); tick(); tick();
    chk("pre_rst_valid", {63'd0, a_valid}, 64'd1);
    rd_reset = 1'b1;
    #1;
    chk("mid_rst_rd_en", {63'd0, a_rd_en}, 64'd0);
    chk("mid_rst_valid", {63'd0, a_valid}, 64'd0);
    chk("mid_rst_data", {32'd0, a_data}, 64'd0);
    chk("mid_rst_last", {63'd0, a_last}, 64'd0);
    chk("mid_rst_wc", {48'd0, a_wc}, 64'd0);
    exp_q.delete();
    a_idx = 0;
    tick(); tick();
    rd_reset = 1'b0;
    a_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_rd_en", {63'd0, a_rd_en}, 64'd0);
      chk("idle_valid", {63'd0, a_valid}, 64'd0);
      tick();
    end

    // PKT_LEN 1 and 4-bit counter wrap over 20 words
    for (int i = 1; i <= 20; i++) push_b(i);
    b_en = 1'b1; b_ready = 1'b1;
    cyc = 0;
    while (b_xfers < 20 && cyc < 60) begin tick(); cyc++; end
    chk("wrap_xfers", 64'(b_xfers), 64'd20);
    chk("wrap_wc", {60'd0, b_wc}, 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
